lfsr_run_ctrl: RTL and testbench

//  Sequencer for the 13-bit XNOR LFSR. Drives the LFSR shift enable and watches its registered state.

---
 rtl/lfsr_run_ctrl_if.sv | 33 +++
 rtl/lfsr_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_run_ctrl_if.sv
// Command/status bundle between the lab control logic, the run controller
// and the LFSR it sequences.
//   start, mode, n_steps : command (mode 0 = run n_steps, 1 = measure period)
//   pause, abort         : level controls for the running command
//   lfsr_q               : registered LFSR state fed back to the controller
//   sh_en                : shift enable to the LFSR, one pulse per step
//   busy, done           : activity level and end-of-command pulse
//   result, status       : command outcome, held until the next command ends
interface lfsr_run_ctrl_if #(
    parameter int WIDTH = 13
);
    logic             start;
    logic             mode;
    logic [15:0]      n_steps;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] lfsr_q;
    logic             sh_en;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic [1:0]       status;

    modport master (
        output start, mode, n_steps, pause, abort, lfsr_q,
        input  sh_en, busy, done, result, status
    );

    modport slave (
        input  start, mode, n_steps, pause, abort, lfsr_q,
        output sh_en, busy, done, result, status
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Sequencer for a 13-bit XNOR LFSR. Owns the LFSR shift enable and watches
// its registered state. Mode 0 performs n_steps shifts and returns the final
// state; mode 1 captures the current state and shifts until it recurs,
// returning the step count (or timing out after MAX_STEPS).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : command/status interface (slave side), see lfsr_run_ctrl_if
module lfsr_run_ctrl #(
    parameter int WIDTH     = 13,
    parameter int Q_LAT     = 2,
    parameter int MAX_STEPS = 8192
) (
    input logic          clk,
    input logic          rst,
    lfsr_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SETTLE, CAPTURE, SHIFT, WAIT, CHECK, DONE
    } state_t;

    localparam logic [2:0]  DLY_LAST  = 3'(Q_LAT - 1);
    localparam logic [15:0] MAX_CNT   = 16'(MAX_STEPS);
    localparam logic [1:0]  ST_OK     = 2'b00;
    localparam logic [1:0]  ST_TIMEOUT = 2'b01;
    localparam logic [1:0]  ST_ABORT  = 2'b10;

    state_t           state, state_n;
    logic [2:0]       dly, dly_n;
    logic [15:0]      cnt, cnt_n;
    logic [WIDTH-1:0] ref_q, ref_n;
    logic             mode_r, mode_n;
    logic [15:0]      nsteps_r, nsteps_n;
    logic [15:0]      result_r, result_n;
    logic [1:0]       status_r, status_n;
    logic             sh_en, done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dly      <= '0;
            cnt      <= '0;
            ref_q    <= '0;
            mode_r   <= 1'b0;
            nsteps_r <= '0;
            result_r <= '0;
            status_r <= '0;
        end else begin
            state    <= state_n;
            dly      <= dly_n;
            cnt      <= cnt_n;
            ref_q    <= ref_n;
            mode_r   <= mode_n;
            nsteps_r <= nsteps_n;
            result_r <= result_n;
            status_r <= status_n;
        end
    end

    always_comb begin
        state_n  = state;
        dly_n    = dly;
        cnt_n    = cnt;
        ref_n    = ref_q;
        mode_n   = mode_r;
        nsteps_n = nsteps_r;
        result_n = result_r;
        status_n = status_r;
        sh_en    = 1'b0;
        done     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    mode_n   = bus.mode;
                    nsteps_n = bus.n_steps;
                    cnt_n    = '0;
                    dly_n    = '0;
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                if (dly == DLY_LAST) begin
                    dly_n   = '0;
                    state_n = CAPTURE;
                end else begin
                    dly_n = dly + 3'd1;
                end
            end
            CAPTURE: begin
                ref_n = bus.lfsr_q;
                if (!mode_r && nsteps_r == '0) begin
                    result_n = 16'(bus.lfsr_q);
                    status_n = ST_OK;
                    state_n  = DONE;
                end else if (!bus.pause) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sh_en   = 1'b1;
                cnt_n   = cnt + 16'd1;
                dly_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (dly == DLY_LAST) begin
                    dly_n   = '0;
                    state_n = CHECK;
                end else begin
                    dly_n = dly + 3'd1;
                end
            end
            CHECK: begin
                if (!mode_r && cnt == nsteps_r) begin
                    result_n = 16'(bus.lfsr_q);
                    status_n = ST_OK;
                    state_n  = DONE;
                end else if (mode_r && bus.lfsr_q == ref_q) begin
                    result_n = cnt;
                    status_n = ST_OK;
                    state_n  = DONE;
                end else if (mode_r && cnt == MAX_CNT) begin
                    result_n = cnt;
                    status_n = ST_TIMEOUT;
                    state_n  = DONE;
                end else if (!bus.pause) begin
                    state_n = SHIFT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides whatever the state decided above, including a
        // completing CHECK and a SHIFT (which then neither pulses nor counts).
        if (bus.abort && state != IDLE && state != DONE) begin
            sh_en    = 1'b0;
            cnt_n    = cnt;
            result_n = cnt;
            status_n = ST_ABORT;
            state_n  = DONE;
        end
    end

    assign bus.sh_en  = sh_en;
    assign bus.done   = done;
    assign bus.busy   = (state != IDLE);
    assign bus.result = result_r;
    assign bus.status = status_r;
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
module tb_lfsr_run_ctrl;
    localparam int WIDTH = 13;
    localparam int Q_LAT = 2;
    localparam int MAXA  = 8192;
    localparam int MAXB  = 100;

    typedef struct {
        logic [15:0] res;
        logic [1:0]  st;
        int          pulses;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, mode = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [15:0] n_steps = '0;
    logic        load = 1'b0;
    logic [WIDTH-1:0] seed_v = '0;

    lfsr_run_ctrl_if #(.WIDTH(WIDTH)) bus_a ();
    lfsr_run_ctrl_if #(.WIDTH(WIDTH)) bus_b ();

    lfsr_run_ctrl #(.WIDTH(WIDTH), .Q_LAT(Q_LAT), .MAX_STEPS(MAXA)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    lfsr_run_ctrl #(.WIDTH(WIDTH), .Q_LAT(Q_LAT), .MAX_STEPS(MAXB)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b));

    assign bus_a.start = start;   assign bus_b.start = start;
    assign bus_a.mode = mode;     assign bus_b.mode = mode;
    assign bus_a.n_steps = n_steps; assign bus_b.n_steps = n_steps;
    assign bus_a.pause = pause;   assign bus_b.pause = pause;
    assign bus_a.abort = abort;   assign bus_b.abort = abort;

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] q);
        return {q[11:0], ~(q[12] ^ q[3] ^ q[2] ^ q[0])};
    endfunction

    // LFSR devices: one register updated by sh_en, plus Q_LAT-1 output stages.
    logic [WIDTH-1:0] dl [2][Q_LAT];
    logic sh [2];
    assign sh[0] = bus_a.sh_en;
    assign sh[1] = bus_b.sh_en;
    assign bus_a.lfsr_q = dl[0][Q_LAT-1];
    assign bus_b.lfsr_q = dl[1][Q_LAT-1];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (load) begin
                for (int i = 0; i < Q_LAT; i++) dl[d][i] <= seed_v;
            end else begin
                for (int i = 1; i < Q_LAT; i++) dl[d][i] <= dl[d][i-1];
                if (sh[d]) dl[d][0] <= nxt(dl[d][0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference: expected outcome from the command rules.
    function automatic exp_t model(input logic m, input int n, input logic [WIDTH-1:0] s0,
                                   input int maxs);
        exp_t e;
        logic [WIDTH-1:0] s = s0;
        int k = 0;
        if (!m) begin
            for (int i = 0; i < n; i++) s = nxt(s);
            e.res = 16'(s); e.st = 2'b00; e.pulses = n;
        end else begin
            do begin
                s = nxt(s);
                k++;
            end while (s != s0 && k < maxs);
            e.res = 16'(k); e.st = (s == s0) ? 2'b00 : 2'b01; e.pulses = k;
        end
        return e;
    endfunction

    // Monitor: per-DUT pulse accounting and done-time scoreboard pops.
    int  pulses [2] = '{0, 0};
    int  last_cyc [2] = '{0, 0};
    bit  have_prev [2] = '{0, 0};
    bit  pause_seen [2] = '{0, 0};
    logic prev_pause = 1'b0;
    int  cyc = 0;

    task automatic mon(input int d, input logic s, input logic dn,
                       input logic [15:0] res, input logic [1:0] st);
        exp_t e;
        if (s) begin
            pulses[d]++;
            chk($sformatf("pause_gate%0d", d), 32'(prev_pause), 32'd0);
            if (have_prev[d]) begin
                if (pause_seen[d])
                    chk($sformatf("step_min%0d", d), 32'(cyc - last_cyc[d] >= Q_LAT + 2), 32'd1);
                else
                    chk($sformatf("step_cost%0d", d), 32'(cyc - last_cyc[d]), 32'(Q_LAT + 2));
            end
            have_prev[d] = 1'b1;
            last_cyc[d] = cyc;
            pause_seen[d] = 1'b0;
        end
        if (pause) pause_seen[d] = 1'b1;
        if (dn) begin
            if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
                chk($sformatf("unexpected_done%0d", d), 32'd1, 32'd0);
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("result%0d", d), 32'(res), 32'(e.res));
                chk($sformatf("status%0d", d), 32'(st), 32'(e.st));
                chk($sformatf("pulses%0d", d), 32'(pulses[d]), 32'(e.pulses));
            end
            pulses[d] = 0;
            have_prev[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                pulses[d] = 0;
                have_prev[d] = 1'b0;
            end
        end else begin
            mon(0, bus_a.sh_en, bus_a.done, bus_a.result, bus_a.status);
            mon(1, bus_b.sh_en, bus_b.done, bus_b.result, bus_b.status);
        end
        prev_pause = pause;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input bit rand_pause);
        int k = 0;
        while ((bus_a.busy || bus_b.busy) && k < 40000) begin
            if (rand_pause) pause = ($urandom_range(0, 3) == 0);
            tick();
            k++;
        end
        pause = 1'b0;
        chk("idle_timeout", 32'(bus_a.busy || bus_b.busy), 32'd0);
        chk("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic wait_pulses(input int k);
        int c = 0;
        int t = 0;
        while (c < k && t < 2000) begin
            tick();
            if (bus_a.sh_en) c++;
            t++;
        end
        chk("pulse_wait", 32'(c), 32'(k));
    endtask

    task automatic issue(input logic [WIDTH-1:0] s, input logic m, input int n, input bit push);
        seed_v = s;
        load = 1'b1;
        tick();
        load = 1'b0;
        mode = m;
        n_steps = 16'(n);
        start = 1'b1;
        if (push) begin
            qa.push_back(model(m, n, s, MAXA));
            qb.push_back(model(m, n, s, MAXB));
        end
        tick();
        start = 1'b0;
        mode = 1'b0;
    endtask

    initial begin
        exp_t e;
        repeat (2) tick();
        chk("rst_sh_en", 32'(bus_a.sh_en), 32'd0);
        chk("rst_busy", 32'(bus_a.busy | bus_b.busy), 32'd0);
        chk("rst_done", 32'(bus_a.done), 32'd0);
        chk("rst_result", 32'(bus_a.result), 32'd0);
        chk("rst_status", 32'(bus_a.status), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Fixed seed, short run.
        issue(13'h1EE, 1'b0, 5, 1'b1);
        wait_idle(1'b0);

        // All-ones lockup: period 1, and zero-step run returns the state.
        issue(13'h1FFF, 1'b1, 0, 1'b1);
        wait_idle(1'b0);
        issue(13'h1FFF, 1'b0, 0, 1'b1);
        wait_idle(1'b0);

        // Pause after the 3rd pulse for 30 cycles.
        issue(13'h0A5, 1'b0, 20, 1'b1);
        wait_pulses(3);
        pause = 1'b1;
        repeat (30) tick();
        pause = 1'b0;
        wait_idle(1'b0);

        // Abort during the WAIT after the 7th pulse.
        issue(13'h123, 1'b0, 20, 1'b0);
        e.res = 16'd7; e.st = 2'b10; e.pulses = 7;
        qa.push_back(e);
        qb.push_back(e);
        wait_pulses(7);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle(1'b0);

        // Reset mid-run: outputs clear at once, no done afterwards.
        issue(13'h0F0, 1'b0, 40, 1'b1);
        wait_pulses(5);
        rst = 1'b1;
        #1;
        chk("arst_sh_en", 32'(bus_a.sh_en | bus_b.sh_en), 32'd0);
        chk("arst_busy", 32'(bus_a.busy | bus_b.busy), 32'd0);
        chk("arst_result", 32'(bus_a.result), 32'd0);
        chk("arst_status", 32'(bus_a.status), 32'd0);
        qa.delete();
        qb.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("post_rst_idle", 32'(bus_a.busy | bus_b.busy), 32'd0);

        // start while busy is ignored.
        issue(13'h0333, 1'b0, 10, 1'b1);
        wait_pulses(2);
        mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = 1'b0;
        wait_idle(1'b0);
        repeat (20) tick();
        chk("no_restart", 32'(bus_a.busy | bus_b.busy), 32'd0);

        // Randomized mode-0 commands with random pause activity.
        for (int i = 0; i < 12; i++) begin
            issue(13'($urandom_range(0, 8190)), 1'b0, int'($urandom_range(0, 40)), 1'b1);
            wait_idle(1'b1);
        end

        // Full period on A; timeout at 100 steps on B.
        issue(13'h1EE, 1'b1, 0, 1'b1);
        wait_idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
